// File: rtl/alu_sequencer.sv
// Command FIFO and issue stage in front of the byte ALU. Read commands (0xE/0xF)
// capture the ALU result two cycles after issue and return it over a valid/ready port.
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_opcode,
    input  logic [7:0] cmd_data,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_data,
    input  logic [7:0] alu_result,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       idle
);
    // DEPTH must be a power of two so the pointers wrap for free.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] data;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_alu_op;
    logic [7:0]    r_alu_data;
    logic [1:0]    r_rd_pipe;
    logic          r_rd_valid;
    logic [7:0]    r_rd_data;

    cmd_t w_head;
    logic w_empty;
    logic w_head_rd;
    logic w_rd_hs;
    logic w_blocked;
    logic w_pop;
    logic w_push;

    assign w_head    = r_mem[r_rptr];
    assign w_empty   = (r_count == '0);
    assign w_head_rd = (w_head.op == 4'hE) || (w_head.op == 4'hF);
    assign w_rd_hs   = r_rd_valid & rd_ready;
    // Only one read byte may be outstanding; a blocked read stalls everything behind it.
    assign w_blocked = w_head_rd & ((|r_rd_pipe) | (r_rd_valid & ~rd_ready));
    assign w_pop     = ~w_empty & ~w_blocked;
    assign w_push    = cmd_valid & cmd_ready;

    assign cmd_ready  = (r_count != CNT_FULL);
    assign idle       = w_empty & ~(|r_rd_pipe) & ~r_rd_valid;
    assign alu_opcode = r_alu_op;
    assign alu_data   = r_alu_data;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{op: cmd_opcode, data: cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_alu_op   <= '0;
            r_alu_data <= '0;
            r_rd_pipe  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            if (w_pop) begin
                r_alu_op   <= w_head.op;
                r_alu_data <= w_head.data;
            end else begin
                r_alu_op   <= 4'h0;
            end

            r_rd_pipe <= {r_rd_pipe[0], w_pop & w_head_rd};
            // A fresh capture takes priority over a same-edge handshake.
            if (r_rd_pipe[1]) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= alu_result;
            end else if (w_rd_hs) begin
                r_rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a cycle-level ALU model drives alu_result, while a
// command-order reference model predicts every byte the host should read back.
module tb_alu_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_data;
    logic [3:0] alu_opcode;
    logic [7:0] alu_data;
    logic [7:0] alu_result;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       idle;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .alu_opcode(alu_opcode),
        .alu_data(alu_data), .alu_result(alu_result), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .idle(idle)
    );

    // ALU semantics: 1 load, 2 add, 3 sub, others nop. Status = {carry, neg, zero}.
    function automatic logic [15:0] alu_step(input logic [3:0] op, input logic [7:0] d,
                                             input logic [7:0] acc, input logic [7:0] st);
        logic [8:0] t;
        logic [7:0] a;
        logic [7:0] s;
        a = acc;
        s = st;
        t = '0;
        case (op)
            4'h1: begin a = d; s = {5'b0, 1'b0, d[7], d == 8'h00}; end
            4'h2: begin t = {1'b0, acc} + {1'b0, d}; a = t[7:0]; s = {5'b0, t[8], a[7], a == 8'h00}; end
            4'h3: begin t = {1'b0, acc} - {1'b0, d}; a = t[7:0]; s = {5'b0, t[8], a[7], a == 8'h00}; end
            default: ;
        endcase
        return {s, a};
    endfunction

    logic [7:0]  m_acc, m_st, m_out;
    logic [15:0] m_nx;
    assign m_nx       = alu_step(alu_opcode, alu_data, m_acc, m_st);
    assign alu_result = m_out;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc <= '0; m_st <= '0; m_out <= '0;
        end else begin
            m_st  <= m_nx[15:8];
            m_acc <= m_nx[7:0];
            m_out <= (alu_opcode == 4'hF) ? m_nx[15:8] : m_nx[7:0];
        end
    end

    // Reference: executes commands in push order, queues the byte each read should return.
    logic [7:0] ref_acc, ref_st;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         n_push;
    logic [3:0] log_op[$];
    logic       log_rv[$];
    logic       log_hs[$];
    logic [7:0] log_rd[$];
    bit         last_push;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic reset_model();
        ref_acc = '0; ref_st = '0; n_push = 0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic model_push(input logic [3:0] op, input logic [7:0] d);
        {ref_st, ref_acc} = alu_step(op, d, ref_acc, ref_st);
        if (op == 4'hE) exp_q.push_back(ref_acc);
        else if (op == 4'hF) exp_q.push_back(ref_st);
        n_push++;
    endtask

    task automatic clear_logs();
        log_op.delete(); log_rv.delete(); log_hs.delete(); log_rd.delete();
    endtask

    task automatic tick();
        logic hs;
        last_push = cmd_valid && cmd_ready;
        if (last_push) model_push(cmd_opcode, cmd_data);
        hs = rd_valid && rd_ready;
        if (hs) got_q.push_back(rd_data);
        @(posedge clk); #1;
        log_op.push_back(alu_opcode); log_rv.push_back(rd_valid);
        log_rd.push_back(rd_data);    log_hs.push_back(hs);
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_data = d;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_push) break;
        end
        if (!last_push) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: op %h not accepted within 20 cycles", op);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_data = '0; rd_ready = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (alu_opcode !== 4'h0) begin n_fail++; $display("FAIL reset_alu_opcode: got %h want 0", alu_opcode); end
        n_checks++; if (alu_data !== 8'h00) begin n_fail++; $display("FAIL reset_alu_data: got %h want 00", alu_data); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    endtask

    task automatic test_pipeline();
        int iE;
        rd_ready = 1'b1; clear_logs();
        push_cmd(4'h1, 8'h05); push_cmd(4'h2, 8'h03); push_cmd(4'hE, 8'h00);
        repeat (6) tick();
        iE = -1;
        foreach (log_op[i]) if (iE < 0 && log_op[i] == 4'hE) iE = i;
        n_checks++;
        if (iE < 2 || iE + 2 >= log_op.size()) begin
            n_fail++; $display("FAIL pipe_find_E: E issued at sample %0d, unusable", iE);
        end else begin
            if (log_op[iE-2] !== 4'h1 || log_op[iE-1] !== 4'h2) begin
                n_fail++; $display("FAIL pipe_order: got %h,%h,E want 1,2,E", log_op[iE-2], log_op[iE-1]);
            end
            n_checks++;
            if (log_rv[iE+1] !== 1'b0 || log_rv[iE+2] !== 1'b1) begin
                n_fail++; $display("FAIL pipe_latency: rd_valid at E+1=%b E+2=%b want 0,1", log_rv[iE+1], log_rv[iE+2]);
            end
            n_checks++;
            if (log_rd[iE+2] !== 8'h08) begin n_fail++; $display("FAIL pipe_rd_data: got %h want 08", log_rd[iE+2]); end
        end
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL pipe_scoreboard: got %0d bytes, want %0d", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_status();
        rd_ready = 1'b1;
        push_cmd(4'h1, 8'h02); push_cmd(4'h2, 8'hFF); push_cmd(4'hF, 8'h00); push_cmd(4'hE, 8'h00);
        repeat (8) tick();
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL status_count: got %0d bytes want 2", got_q.size());
        end else begin
            n_checks++; if (got_q[0] !== 8'h04) begin n_fail++; $display("FAIL status_carry: got %h want 04", got_q[0]); end
            n_checks++; if (got_q[1] !== 8'h01) begin n_fail++; $display("FAIL status_accum: got %h want 01", got_q[1]); end
        end
        push_cmd(4'h1, 8'h08); push_cmd(4'h3, 8'h08); push_cmd(4'hF, 8'h00);
        repeat (6) tick();
        n_checks++;
        if (got_q.size() != 3 || got_q[2] !== 8'h01) begin
            n_fail++; $display("FAIL status_zero: got %0d bytes, last %h want 01", got_q.size(), got_q[got_q.size()-1]);
        end
        n_checks++;
        if (got_q != exp_q) begin n_fail++; $display("FAIL status_scoreboard: got %p want %p", got_q, exp_q); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_read_block();
        int n_e;
        int i2;
        int iE2;
        rd_ready = 1'b0; clear_logs();
        push_cmd(4'h1, 8'h5A); push_cmd(4'hE, 8'h00); push_cmd(4'hE, 8'h00); push_cmd(4'h2, 8'h01);
        repeat (8) tick();
        n_e = 0;
        foreach (log_op[i]) if (log_op[i] == 4'hE) n_e++;
        n_checks++; if (n_e != 1) begin n_fail++; $display("FAIL block_issue_count: %0d reads issued want 1", n_e); end
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin n_fail++; $display("FAIL block_capture: valid %b data %h want 1 5A", rd_valid, rd_data); end
        n_checks++; if (alu_opcode !== 4'h0 || idle !== 1'b0) begin n_fail++; $display("FAIL block_stall: opcode %h idle %b want 0 0", alu_opcode, idle); end
        clear_logs();
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        repeat (6) tick();
        iE2 = -1; i2 = -1;
        foreach (log_op[i]) begin
            if (iE2 < 0 && log_op[i] == 4'hE) iE2 = i;
            if (i2 < 0 && log_op[i] == 4'h2) i2 = i;
        end
        n_checks++; if (iE2 != 0 || i2 != 1) begin n_fail++; $display("FAIL block_release_order: E at %0d add at %0d want 0 1", iE2, i2); end
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin n_fail++; $display("FAIL block_second_read: valid %b data %h want 1 5A", rd_valid, rd_data); end
        rd_ready = 1'b1; repeat (3) tick();
        n_checks++;
        if (got_q != exp_q || got_q.size() != 2) begin n_fail++; $display("FAIL block_scoreboard: got %p want %p", got_q, exp_q); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_full();
        int np;
        rd_ready = 1'b0;
        push_cmd(4'hE, 8'h00);
        repeat (4) tick();
        for (int k = 0; k < DEPTH; k++) push_cmd((k == 0) ? 4'hE : 4'h2, 8'(k));
        np = n_push;
        cmd_valid = 1'b1; cmd_opcode = 4'h1; cmd_data = 8'h33;
        repeat (3) tick();
        n_checks++; if (cmd_ready !== 1'b0 || n_push != np) begin n_fail++; $display("FAIL full_ready: cmd_ready %b extra pushes %0d want 0 0", cmd_ready, n_push - np); end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_restore: cmd_ready %b want 1", cmd_ready); end
        tick(); cmd_valid = 1'b0;
        n_checks++; if (n_push != np + 1) begin n_fail++; $display("FAIL full_extra_lost: pushes %0d want %0d", n_push - np, 1); end
        rd_ready = 1'b1; repeat (14) tick();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_drain_idle: idle %b want 1", idle); end
        n_checks++; if (got_q != exp_q || got_q.size() != 2) begin n_fail++; $display("FAIL full_scoreboard: got %p want %p", got_q, exp_q); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int np0;
        int n_iss;
        int w;
        logic [3:0] op;
        clear_logs(); np0 = n_push; cmd_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!cmd_valid || last_push) begin
                case ($urandom_range(0, 7))
                    0, 7:    op = 4'h1;
                    1, 6:    op = 4'h2;
                    2:       op = 4'h3;
                    3:       op = 4'hE;
                    4:       op = 4'hF;
                    default: op = 4'($urandom_range(4, 13));
                endcase
                cmd_valid = ($urandom_range(0, 3) != 0); cmd_opcode = op; cmd_data = 8'($urandom);
            end
            rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_valid = 1'b0; rd_ready = 1'b1; w = 0;
        while (!idle && w < 100) begin tick(); w++; end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rand_drain: idle %b after %0d cycles", idle, w); end
        n_iss = 0;
        foreach (log_op[i]) if (log_op[i] != 4'h0) n_iss++;
        n_checks++; if (n_iss != n_push - np0) begin n_fail++; $display("FAIL rand_issue_count: issued %0d want %0d", n_iss, n_push - np0); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_read_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_read_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i + 1 < log_rv.size(); i++) begin
            if (log_rv[i] && !log_hs[i+1]) begin
                n_checks++;
                if (log_rv[i+1] !== 1'b1 || log_rd[i+1] !== log_rd[i]) begin
                    n_fail++; $display("FAIL rand_hold_%0d: valid %b data %h want 1 %h", i, log_rv[i+1], log_rd[i+1], log_rd[i]);
                end
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int n_bad;
        rd_ready = 1'b1;
        push_cmd(4'h1, 8'h77); push_cmd(4'hE, 8'h55);
        repeat (5) tick();
        push_cmd(4'hE, 8'h99);
        cmd_valid = 1'b1; cmd_opcode = 4'h2; cmd_data = 8'h11; tick();
        n_checks++; if (alu_opcode !== 4'hE || rd_data !== 8'h77) begin n_fail++; $display("FAIL rstmid_setup: opcode %h rd_data %h want E 77", alu_opcode, rd_data); end
        cmd_data = 8'h22; tick();
        cmd_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_checks++; if (alu_opcode !== 4'h0 || alu_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_alu: opcode %h data %h want 0 00", alu_opcode, alu_data); end
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rd: valid %b data %h want 0 00", rd_valid, rd_data); end
        n_checks++; if (cmd_ready !== 1'b1 || idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_flags: ready %b idle %b want 1 1", cmd_ready, idle); end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        reset_model(); clear_logs();
        @(posedge clk); #1;
        repeat (8) tick();
        n_bad = 0;
        foreach (log_op[i]) if (log_op[i] != 4'h0 || log_rv[i]) n_bad++;
        n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d cycles with activity want 0", n_bad); end
        n_checks++; if (idle !== 1'b1 || got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_idle: idle %b reads %0d want 1 0", idle, got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_status();
        test_read_block();
        test_full();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
